vram_cpu_port: RTL and testbench

//  Initiator side of the HuC6270 VRAM port: turns CPU byte accesses to VDC regs MAWR(0), MARR(1), VWR/VRR(2)

---
 rtl/huc6270_pkg.sv | 36 +++
 rtl/vram_cpu_port.sv | 159 +++++++++++++++
 tb/tb_vram_cpu_port.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/huc6270_pkg.sv
// Shared types and helpers for the HuC6270 VRAM CPU port.
//   vdc_reg_t          : VDC address-register codes handled by the port
//   vram_port_state_t  : VRAM cycle sequencer states
//   incr_step()        : CR[12:11] auto-increment decode
package huc6270_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned READ_LAT = 1;

  typedef enum logic [4:0] {
    REG_MAWR  = 5'h00,
    REG_MARR  = 5'h01,
    REG_VDATA = 5'h02
  } vdc_reg_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } vram_port_state_t;

  // Auto-increment step selected by CR[12:11].
  function automatic logic [ADDR_W-1:0] incr_step(input logic [1:0] sel);
    logic [ADDR_W-1:0] step;
    case (sel)
      2'b00:   step = ADDR_W'(1);
      2'b01:   step = ADDR_W'(32);
      2'b10:   step = ADDR_W'(64);
      default: step = ADDR_W'(128);
    endcase
    return step;
  endfunction

endpackage

// File: rtl/vram_cpu_port.sv
// CPU-side VRAM access port of the HuC6270 VDC.
// Converts host byte accesses to MAWR/MARR/VWR/VRR into single-word VRAM
// read/write cycles with auto-increment, arbitrated by vram_req/vram_gnt.
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   host_wr/host_rd              : 1-cycle host access pulses
//   host_reg/host_hi/host_wdata  : register select, byte select, write byte
//   host_rdata                   : registered read byte (valid cycle after host_rd)
//   incr_sel                     : CR[12:11] auto-increment select
//   busy, overrun                : cycle in progress / sticky dropped-command flag
//   vram_req, vram_gnt           : slot request / arbiter grant (may be same-cycle)
//   MA, re, we, MD_wr, MD_rd     : VRAM address, strobes, write and read data
module vram_cpu_port #(
  parameter int unsigned ADDR_W   = huc6270_pkg::ADDR_W,
  parameter int unsigned DATA_W   = huc6270_pkg::DATA_W,
  parameter int unsigned READ_LAT = huc6270_pkg::READ_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic [4:0]        host_reg,
  input  logic              host_hi,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  input  logic [1:0]        incr_sel,
  output logic              busy,
  output logic              overrun,
  output logic              vram_req,
  input  logic              vram_gnt,
  output logic [ADDR_W-1:0] MA,
  output logic              re,
  output logic              we,
  output logic [DATA_W-1:0] MD_wr,
  input  logic [DATA_W-1:0] MD_rd
);

  import huc6270_pkg::*;

  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  vram_port_state_t  state, state_next;
  logic [ADDR_W-1:0] mawr, marr, step_q;
  logic [DATA_W-1:0] vwr, vrr;
  logic [LAT_W-1:0]  lat_cnt;

  logic is_idle, wr_take, rd_take, drop;
  logic start_wr, start_rd, rd_incr, lat_done;

  // Command decode: accept only in IDLE, write wins over a simultaneous read.
  always_comb begin
    is_idle  = (state == IDLE);
    wr_take  = is_idle && host_wr;
    rd_take  = is_idle && host_rd && !host_wr;
    drop     = (!is_idle && (host_wr || host_rd)) || (is_idle && host_wr && host_rd);
    start_wr = wr_take && (host_reg == REG_VDATA) && host_hi;
    rd_incr  = rd_take && (host_reg == REG_VDATA) && host_hi;
    start_rd = (wr_take && (host_reg == REG_MARR) && host_hi) || rd_incr;
    lat_done = (lat_cnt == LAT_W'(READ_LAT - 1));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_next = WR_REQ;
        else if (start_rd) state_next = RD_REQ;
      end
      RD_REQ:  if (vram_gnt) state_next = RD_WAIT;
      RD_WAIT: if (lat_done) state_next = IDLE;
      WR_REQ:  if (vram_gnt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // VRAM-side outputs; strobes follow the grant in the request states.
  always_comb begin
    vram_req = 1'b0;
    re       = 1'b0;
    we       = 1'b0;
    MA       = '0;
    MD_wr    = '0;
    case (state)
      RD_REQ: begin
        vram_req = 1'b1;
        MA       = marr;
        re       = vram_gnt;
      end
      WR_REQ: begin
        vram_req = 1'b1;
        MA       = mawr;
        MD_wr    = vwr;
        we       = vram_gnt;
      end
      default: ;
    endcase
  end

  assign busy = !is_idle;

  // Host-visible registers, address pointers and read-latency counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      mawr       <= '0;
      marr       <= '0;
      vwr        <= '0;
      vrr        <= '0;
      step_q     <= '0;
      lat_cnt    <= '0;
      host_rdata <= '0;
      overrun    <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;

      if (wr_take) begin
        case (host_reg)
          REG_MAWR: begin
            if (host_hi) mawr <= ADDR_W'({host_wdata, mawr[7:0]});
            else         mawr <= ADDR_W'({mawr[ADDR_W-1:8], host_wdata});
          end
          REG_MARR: begin
            if (host_hi) marr <= ADDR_W'({host_wdata, marr[7:0]});
            else         marr <= ADDR_W'({marr[ADDR_W-1:8], host_wdata});
          end
          REG_VDATA: begin
            if (host_hi) vwr <= DATA_W'({host_wdata, vwr[7:0]});
            else         vwr <= DATA_W'({vwr[DATA_W-1:8], host_wdata});
          end
          default: ;
        endcase
      end

      if (rd_take) begin
        if (host_reg == REG_VDATA) host_rdata <= host_hi ? vrr[15:8] : vrr[7:0];
        else                       host_rdata <= 8'h00;
      end

      // Step is frozen at trigger so a CR change mid-cycle has no effect.
      if (start_wr || start_rd) step_q <= incr_step(incr_sel);
      if (rd_incr)              marr   <= marr + incr_step(incr_sel);

      if (state == WR_REQ && vram_gnt) mawr <= mawr + step_q;

      if (state == RD_REQ) lat_cnt <= '0;
      else if (state == RD_WAIT) begin
        if (lat_done) vrr     <= MD_rd;
        else          lat_cnt <= lat_cnt + LAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Self-checking bench for vram_cpu_port: behavioural VRAM responder,
// scoreboards for VRAM cycles and host read data.
module tb_vram_cpu_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        host_wr, host_rd, host_hi;
  logic [4:0]  host_reg;
  logic [7:0]  host_wdata, host_rdata;
  logic [1:0]  incr_sel;
  logic        busy, overrun, vram_req, vram_gnt, re, we;
  logic [15:0] MA, MD_wr, MD_rd;

  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [15:0] data;
  } vop_t;

  vop_t       exp_vop_q[$];
  logic [7:0] exp_rd_q[$];
  logic [15:0] mem [0:65535];
  int n_tests = 0;
  int n_fail  = 0;
  int re_cnt  = 0;
  int we_cnt  = 0;

  vram_cpu_port dut (
    .clock(clock), .reset(reset),
    .host_wr(host_wr), .host_rd(host_rd), .host_reg(host_reg), .host_hi(host_hi),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .incr_sel(incr_sel),
    .busy(busy), .overrun(overrun), .vram_req(vram_req), .vram_gnt(vram_gnt),
    .MA(MA), .re(re), .we(we), .MD_wr(MD_wr), .MD_rd(MD_rd)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // VRAM responder with registered read data.
  logic [15:0] md_q = 16'h0;
  assign MD_rd = md_q;
  always @(posedge clock) begin
    if (we) mem[MA] <= MD_wr;
    if (re) md_q <= mem[MA];
  end

  // VRAM cycle monitor against the expected-cycle queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (re && we) chk("re_we_both", 1, 0);
      if (re || we) begin
        if (re) re_cnt++;
        if (we) we_cnt++;
        if (exp_vop_q.size() == 0) chk("vram_unexpected", 1, 0);
        else begin
          vop_t e;
          e = exp_vop_q.pop_front();
          chk("vram_kind", 32'(we), 32'(e.is_wr));
          chk("vram_addr", 32'(MA), 32'(e.addr));
          if (we) chk("vram_wdata", 32'(MD_wr), 32'(e.data));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic host_write(input logic [4:0] r, input logic hi, input logic [7:0] d);
    host_wr = 1'b1; host_reg = r; host_hi = hi; host_wdata = d;
    cyc();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] r, input logic hi, input logic [7:0] exp);
    exp_rd_q.push_back(exp);
    host_rd = 1'b1; host_reg = r; host_hi = hi;
    cyc();
    host_rd = 1'b0;
    chk("host_rdata", 32'(host_rdata), 32'(exp_rd_q.pop_front()));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      cyc();
      n++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    exp_vop_q.push_back('{is_wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [15:0] a);
    exp_vop_q.push_back('{is_wr: 1'b0, addr: a, data: 16'h0});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0200] = 16'hBEEF;
    mem[16'h0220] = 16'h5A5A;
    reset = 1'b1; host_wr = 0; host_rd = 0; host_reg = 0; host_hi = 0;
    host_wdata = 0; incr_sel = 0; vram_gnt = 1'b1;
    do_reset();

    chk("rst_MA", 32'(MA), 0);
    chk("rst_re", 32'(re), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_req", 32'(vram_req), 0);
    chk("rst_MD_wr", 32'(MD_wr), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Basic write with +1.
    host_write(5'h00, 0, 8'h34);
    host_write(5'h00, 1, 8'h12);
    host_write(5'h02, 0, 8'hCD);
    exp_wr(16'h1234, 16'hABCD);
    w0 = we_cnt;
    host_write(5'h02, 1, 8'hAB);
    wait_idle(n);
    chk("wr_latency", 32'(n), 1);
    chk("wr_we_pulses", 32'(we_cnt - w0), 1);
    chk("mem_1234", 32'(mem[16'h1234]), 32'hABCD);
    exp_wr(16'h1235, 16'h11CD);
    host_write(5'h02, 1, 8'h11);
    wait_idle(n);

    // Read path with +32.
    incr_sel = 2'b01;
    host_write(5'h01, 0, 8'h00);
    exp_rd(16'h0200);
    w0 = re_cnt;
    host_write(5'h01, 1, 8'h02);
    wait_idle(n);
    chk("rd_latency", 32'(n), 2);
    chk("rd_re_pulses", 32'(re_cnt - w0), 1);
    host_read(5'h02, 0, 8'hEF);
    exp_rd(16'h0220);
    host_read(5'h02, 1, 8'hBE);
    wait_idle(n);
    host_read(5'h02, 0, 8'h5A);
    host_read(5'h02, 1, 8'h5A);
    exp_rd(16'h0240);
    wait_idle(n);

    // Wrap-around with +64 and +128.
    incr_sel = 2'b10;
    host_write(5'h00, 0, 8'hF0);
    host_write(5'h00, 1, 8'hFF);
    host_write(5'h02, 0, 8'h00);
    exp_wr(16'hFFF0, 16'h0100); host_write(5'h02, 1, 8'h01); wait_idle(n);
    exp_wr(16'h0030, 16'h0200); host_write(5'h02, 1, 8'h02); wait_idle(n);
    incr_sel = 2'b11;
    host_write(5'h00, 0, 8'h80);
    host_write(5'h00, 1, 8'hFF);
    exp_wr(16'hFF80, 16'h0300); host_write(5'h02, 1, 8'h03); wait_idle(n);
    exp_wr(16'h0000, 16'h0400); host_write(5'h02, 1, 8'h04); wait_idle(n);

    // Grant stall with a dropped command.
    incr_sel = 2'b00;
    host_write(5'h00, 0, 8'h00);
    host_write(5'h00, 1, 8'h40);
    vram_gnt = 1'b0;
    exp_wr(16'h4000, 16'h7700);
    host_write(5'h02, 1, 8'h77);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(vram_req), 1);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_we", 32'(we), 0);
      host_wr = (i == 1); host_reg = 5'h00; host_hi = 0; host_wdata = 8'h55;
      cyc();
    end
    host_wr = 1'b0;
    chk("stall_overrun", 32'(overrun), 1);
    w0 = we_cnt;
    vram_gnt = 1'b1;
    wait_idle(n);
    chk("stall_we_pulses", 32'(we_cnt - w0), 1);
    exp_wr(16'h4001, 16'h7800);
    host_write(5'h02, 1, 8'h78);
    wait_idle(n);

    // Reset clears overrun; simultaneous wr+rd.
    do_reset();
    chk("rst2_overrun", 32'(overrun), 0);
    host_write(5'h01, 0, 8'h20);
    exp_rd(16'h0220);
    host_write(5'h01, 1, 8'h02);
    wait_idle(n);
    host_read(5'h02, 0, 8'h5A);
    host_wr = 1'b1; host_rd = 1'b1; host_reg = 5'h00; host_hi = 0; host_wdata = 8'h10;
    cyc();
    host_wr = 1'b0; host_rd = 1'b0;
    chk("both_rdata_held", 32'(host_rdata), 32'h5A);
    chk("both_overrun", 32'(overrun), 1);
    chk("both_busy", 32'(busy), 0);
    host_write(5'h00, 1, 8'h30);
    exp_wr(16'h3010, 16'h9900);
    host_write(5'h02, 1, 8'h99);
    wait_idle(n);
    host_read(5'h05, 0, 8'h00);

    // Reset during RD_WAIT discards the late read data.
    host_write(5'h01, 0, 8'h00);
    exp_rd(16'h0200);
    host_write(5'h01, 1, 8'h02);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_re", 32'(re), 0);
    chk("rstw_we", 32'(we), 0);
    cyc(); cyc();
    host_read(5'h02, 0, 8'h00);

    cyc(); cyc();
    chk("vop_queue_drained", 32'(exp_vop_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
